// File: rtl/threshold_pkg.sv
// Shared types, constants and actor handshake macro for the threshold frame scheduler.
`ifndef THRESHOLD_PKG_SV
`define THRESHOLD_PKG_SV

// A token moves when the producer sends and the consumer is ready.
`define ACTOR_FIRE(send, rdy) ((send) & (rdy))

package threshold_pkg;

    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned ACTOR_COUNT_W = 16;

    localparam logic [DEF_DATA_W-1:0] PIX_MAX = '1;

    typedef enum logic {
        S_CFG = 1'b0,
        S_RUN = 1'b1
    } state_e;

endpackage

`endif

// File: rtl/threshold_frame_counter.sv
// Pixel counter with enable, synchronous clear and a terminal-count flag.
module threshold_frame_counter #(
    parameter int unsigned      CNT_W = 18,
    parameter logic [CNT_W-1:0] LAST  = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o,
    output logic             tc_c
);

    logic [CNT_W-1:0] count_q, count_d;

    // Clear wins over increment so the terminal pixel returns the count to zero.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_c    = (count_q == LAST);

endmodule

// File: rtl/threshold_frame_scheduler.sv
// Frame sequencer for the threshold actor: one config token, then a frame of pixels,
// each binarised against the latched threshold with one cycle of latency.
module threshold_frame_scheduler
    import threshold_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned FRAME_W = 512,
    parameter int unsigned FRAME_H = 512,
    parameter int unsigned CNT_W   = 18,
    parameter bit          INVERT  = 1'b0
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [DATA_W-1:0]        Cfg_DATA,
    input  logic                     Cfg_SEND,
    input  logic [ACTOR_COUNT_W-1:0] Cfg_COUNT,
    output logic                     Cfg_ACK,
    input  logic [DATA_W-1:0]        In1_DATA,
    input  logic                     In1_SEND,
    input  logic [ACTOR_COUNT_W-1:0] In1_COUNT,
    output logic                     In1_ACK,
    input  logic                     Out1_RDY,
    input  logic                     Out1_ACK,
    output logic [DATA_W-1:0]        Out1_DATA,
    output logic                     Out1_SEND,
    output logic [ACTOR_COUNT_W-1:0] Out1_COUNT,
    output logic                     frame_done,
    output logic [CNT_W-1:0]         pix_count
);

    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_W * FRAME_H - 1);

    state_e                   state_q, state_d;
    logic [DATA_W-1:0]        thresh_q, thresh_d;
    logic [DATA_W-1:0]        out_data_q;
    logic                     out_send_q;
    logic [ACTOR_COUNT_W-1:0] out_count_q;
    logic                     frame_done_q;
    logic                     cfg_hs;
    logic                     fire;
    logic                     hit;
    logic                     last_pix;

    logic unused_ok;
    assign unused_ok = ^{Cfg_COUNT, In1_COUNT, Out1_ACK};

    threshold_frame_counter #(
        .CNT_W (CNT_W),
        .LAST  (LAST_PIX)
    ) u_counter (
        .clk     (CLK),
        .rst_n   (RESET),
        .en_i    (fire),
        .clr_i   (fire & last_pix),
        .count_o (pix_count),
        .tc_c    (last_pix)
    );

    // Next-state and handshake decode; config is only accepted between frames.
    always_comb begin
        state_d  = state_q;
        thresh_d = thresh_q;
        cfg_hs   = 1'b0;
        fire     = 1'b0;
        case (state_q)
            S_CFG: begin
                cfg_hs = Cfg_SEND;
                if (cfg_hs) begin
                    thresh_d = Cfg_DATA;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                fire = `ACTOR_FIRE(In1_SEND, Out1_RDY);
                if (fire && last_pix) begin
                    state_d = S_CFG;
                end
            end
            default: state_d = S_CFG;
        endcase
    end

    assign hit     = (In1_DATA > thresh_q) ^ INVERT;
    assign Cfg_ACK = cfg_hs & RESET;
    assign In1_ACK = fire;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= S_CFG;
            thresh_q     <= '0;
            out_data_q   <= '0;
            out_send_q   <= 1'b0;
            out_count_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            thresh_q     <= thresh_d;
            out_send_q   <= fire;
            out_count_q  <= fire ? ACTOR_COUNT_W'(1) : '0;
            frame_done_q <= fire & last_pix;
            if (fire) begin
                out_data_q <= hit ? {DATA_W{1'b1}} : '0;
            end
        end
    end

    assign Out1_DATA  = out_data_q;
    assign Out1_SEND  = out_send_q;
    assign Out1_COUNT = out_count_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_threshold_frame_scheduler.sv
// Bench for threshold_frame_scheduler: a normal and an inverting instance share stimulus and
// are checked against per-frame token expectations derived from threshold and pixel values.
module tb_threshold_frame_scheduler;
    import threshold_pkg::*;

    typedef struct packed {
        logic [7:0] d0;
        logic [7:0] d1;
        logic       last;
    } tok_t;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [7:0]  Cfg_DATA;
    logic        Cfg_SEND;
    logic [15:0] Cfg_COUNT;
    logic [7:0]  In1_DATA;
    logic        In1_SEND;
    logic [15:0] In1_COUNT;
    logic        Out1_RDY;
    logic        Out1_ACK;

    logic        c_ack0, c_ack1, i_ack0, i_ack1;
    logic [7:0]  o_data0, o_data1;
    logic        o_send0, o_send1;
    logic [15:0] o_cnt0, o_cnt1;
    logic        fd0, fd1;
    logic [2:0]  pc0, pc1;

    int   n_checks = 0;
    int   n_errors = 0;
    tok_t exp_q[$];
    logic prev_ack = 1'b0;

    always #5 CLK = ~CLK;

    threshold_frame_scheduler #(.DATA_W(8), .FRAME_W(4), .FRAME_H(2), .CNT_W(3), .INVERT(1'b0)) dut0 (
        .CLK(CLK), .RESET(RESET),
        .Cfg_DATA(Cfg_DATA), .Cfg_SEND(Cfg_SEND), .Cfg_COUNT(Cfg_COUNT), .Cfg_ACK(c_ack0),
        .In1_DATA(In1_DATA), .In1_SEND(In1_SEND), .In1_COUNT(In1_COUNT), .In1_ACK(i_ack0),
        .Out1_RDY(Out1_RDY), .Out1_ACK(Out1_ACK), .Out1_DATA(o_data0), .Out1_SEND(o_send0),
        .Out1_COUNT(o_cnt0), .frame_done(fd0), .pix_count(pc0)
    );

    threshold_frame_scheduler #(.DATA_W(8), .FRAME_W(4), .FRAME_H(2), .CNT_W(3), .INVERT(1'b1)) dut1 (
        .CLK(CLK), .RESET(RESET),
        .Cfg_DATA(Cfg_DATA), .Cfg_SEND(Cfg_SEND), .Cfg_COUNT(Cfg_COUNT), .Cfg_ACK(c_ack1),
        .In1_DATA(In1_DATA), .In1_SEND(In1_SEND), .In1_COUNT(In1_COUNT), .In1_ACK(i_ack1),
        .Out1_RDY(Out1_RDY), .Out1_ACK(Out1_ACK), .Out1_DATA(o_data1), .Out1_SEND(o_send1),
        .Out1_COUNT(o_cnt1), .frame_done(fd1), .pix_count(pc1)
    );

    // Output monitor: a token appears exactly one cycle after each accepted pixel, in order.
    always @(negedge CLK) begin
        if (RESET !== 1'b1) begin
            prev_ack = 1'b0;
        end else begin
            n_checks++;
            if (o_send0 !== prev_ack || o_send1 !== prev_ack) begin
                n_errors++;
                $display("FAIL out_send_timing: got %b/%b expected %b", o_send0, o_send1, prev_ack);
            end
            n_checks++;
            if (i_ack1 !== i_ack0) begin
                n_errors++;
                $display("FAIL ack_agree: inv instance %b normal %b", i_ack1, i_ack0);
            end
            if (o_send0 === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL extra_token: data %0h with nothing expected", o_data0);
                end else begin
                    tok_t e;
                    e = exp_q.pop_front();
                    n_checks++;
                    if (o_data0 !== e.d0 || o_data1 !== e.d1) begin
                        n_errors++;
                        $display("FAIL out_data: got %0h/%0h expected %0h/%0h", o_data0, o_data1, e.d0, e.d1);
                    end
                    n_checks++;
                    if (fd0 !== e.last || fd1 !== e.last) begin
                        n_errors++;
                        $display("FAIL frame_done: got %b/%b expected %b", fd0, fd1, e.last);
                    end
                    n_checks++;
                    if (o_cnt0 !== 16'h1 || o_cnt1 !== 16'h1) begin
                        n_errors++;
                        $display("FAIL out_count: got %0h/%0h expected 1", o_cnt0, o_cnt1);
                    end
                end
            end else begin
                n_checks++;
                if (o_cnt0 !== 16'h0 || fd0 !== 1'b0 || fd1 !== 1'b0) begin
                    n_errors++;
                    $display("FAIL idle_outputs: count %0h done %b/%b expected 0", o_cnt0, fd0, fd1);
                end
            end
            prev_ack = i_ack0;
        end
    end

    // Sends one config token then one 4x2 frame; optionally aborts with a reset after abort_at pixels.
    task automatic drive_frame(input logic [7:0] thr, input logic [7:0] pix [8], input int rdy_mode,
                               input bit rand_send, input bit hold_next, input logic [7:0] next_thr,
                               input bit expect_now, input int abort_at);
        int waits;
        int idx;
        int cyc;
        for (int i = 0; i < 8; i++) begin
            tok_t t;
            t.d0   = (pix[i] > thr) ? 8'hFF : 8'h00;
            t.d1   = (pix[i] > thr) ? 8'h00 : 8'hFF;
            t.last = (i == 7);
            exp_q.push_back(t);
        end
        Cfg_DATA = thr;
        Cfg_SEND = 1'b1;
        waits    = 0;
        forever begin
            @(negedge CLK);
            n_checks++;
            if (i_ack0 !== 1'b0) begin
                n_errors++;
                $display("FAIL in_ack_in_cfg: got %b expected 0", i_ack0);
            end
            if (c_ack0 === 1'b1) break;
            waits++;
            if (waits > 50) begin
                n_checks++;
                n_errors++;
                $display("FAIL cfg_timeout: waited %0d cycles expected ack", waits);
                Cfg_SEND = 1'b0;
                return;
            end
            @(posedge CLK); #1;
        end
        if (expect_now) begin
            n_checks++;
            if (waits != 0) begin
                n_errors++;
                $display("FAIL cfg_earliest: waited %0d cycles expected 0", waits);
            end
        end
        @(posedge CLK); #1;
        Cfg_SEND = hold_next;
        Cfg_DATA = next_thr;
        idx = 0;
        cyc = 0;
        while (idx < 8) begin
            In1_DATA = pix[idx];
            In1_SEND = rand_send ? 1'($urandom_range(0, 1)) : 1'b1;
            case (rdy_mode)
                0:       Out1_RDY = 1'b1;
                1:       Out1_RDY = (cyc % 2 == 0);
                default: Out1_RDY = 1'($urandom_range(0, 1));
            endcase
            @(negedge CLK);
            n_checks++;
            if (i_ack0 !== (In1_SEND & Out1_RDY)) begin
                n_errors++;
                $display("FAIL in_ack: got %b expected %b", i_ack0, In1_SEND & Out1_RDY);
            end
            n_checks++;
            if (pc0 !== 3'(idx) || pc1 !== 3'(idx)) begin
                n_errors++;
                $display("FAIL pix_count: got %0d/%0d expected %0d", pc0, pc1, idx);
            end
            if (hold_next) begin
                n_checks++;
                if (c_ack0 !== 1'b0) begin
                    n_errors++;
                    $display("FAIL cfg_held_off: got %b expected 0", c_ack0);
                end
            end
            if (i_ack0 === 1'b1) idx++;
            cyc++;
            if (abort_at >= 0 && idx == abort_at) begin
                @(posedge CLK); #1;
                RESET    = 1'b0;
                In1_SEND = 1'b0;
                Cfg_SEND = 1'b0;
                #1;
                n_checks++;
                if (o_send0 !== 1'b0 || o_data0 !== 8'h00 || o_data1 !== 8'h00 || o_cnt0 !== 16'h0 || fd0 !== 1'b0) begin
                    n_errors++;
                    $display("FAIL async_reset_out: send %b data %0h/%0h count %0h done %b expected all 0",
                             o_send0, o_data0, o_data1, o_cnt0, fd0);
                end
                n_checks++;
                if (pc0 !== 3'd0 || pc1 !== 3'd0) begin
                    n_errors++;
                    $display("FAIL async_reset_count: got %0d/%0d expected 0", pc0, pc1);
                end
                exp_q.delete();
                @(posedge CLK); #1;
                RESET = 1'b1;
                return;
            end
            if (cyc > 200) begin
                n_checks++;
                n_errors++;
                $display("FAIL pixel_timeout: %0d of 8 pixels accepted", idx);
                return;
            end
            @(posedge CLK); #1;
        end
        In1_SEND = hold_next;
        Out1_RDY = 1'b1;
    endtask

    task automatic test_reset();
        RESET     = 1'b0;
        Cfg_DATA  = 8'd77;
        Cfg_SEND  = 1'b1;
        Cfg_COUNT = 16'h1;
        In1_DATA  = 8'd0;
        In1_SEND  = 1'b1;
        In1_COUNT = 16'h1;
        Out1_RDY  = 1'b1;
        Out1_ACK  = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        n_checks++;
        if (o_send0 !== 1'b0 || o_data0 !== 8'h00 || o_cnt0 !== 16'h0 || fd0 !== 1'b0 || pc0 !== 3'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: send %b data %0h count %0h done %b pix %0d expected 0",
                     o_send0, o_data0, o_cnt0, fd0, pc0);
        end
        n_checks++;
        if (c_ack0 !== 1'b0 || i_ack0 !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_acks: cfg %b in %b expected 0", c_ack0, i_ack0);
        end
        @(posedge CLK); #1;
        Cfg_SEND = 1'b0;
        In1_SEND = 1'b0;
        RESET    = 1'b1;
    endtask

    task automatic test_basic_frame();
        logic [7:0] p [8];
        p = '{8'd0, 8'd99, 8'd100, 8'd101, 8'd200, 8'd255, 8'd50, 8'd150};
        drive_frame(8'd100, p, 0, 1'b0, 1'b0, 8'd0, 1'b0, -1);
    endtask

    task automatic test_rdy_toggle();
        logic [7:0] p [8];
        p = '{8'd0, 8'd99, 8'd100, 8'd101, 8'd200, 8'd255, 8'd50, 8'd150};
        drive_frame(8'd100, p, 1, 1'b0, 1'b0, 8'd0, 1'b0, -1);
    endtask

    task automatic test_cfg_hold();
        logic [7:0] p [8];
        p = '{8'd0, 8'd99, 8'd100, 8'd101, 8'd200, 8'd255, 8'd160, 8'd150};
        drive_frame(8'd100, p, 0, 1'b0, 1'b1, 8'd160, 1'b0, -1);
        drive_frame(8'd160, p, 0, 1'b0, 1'b0, 8'd0, 1'b1, -1);
    endtask

    task automatic test_mid_frame_reset();
        logic [7:0] p [8];
        logic [7:0] q [8];
        p = '{8'd10, 8'd200, 8'd30, 8'd220, 8'd40, 8'd240, 8'd50, 8'd250};
        q = '{8'd128, 8'd127, 8'd129, 8'd0, 8'd255, 8'd64, 8'd192, 8'd128};
        drive_frame(8'd100, p, 0, 1'b0, 1'b0, 8'd0, 1'b0, 3);
        drive_frame(8'd128, q, 0, 1'b0, 1'b0, 8'd0, 1'b0, -1);
    endtask

    task automatic test_invert_boundaries();
        logic [7:0] p [8];
        p = '{PIX_MAX, PIX_MAX, PIX_MAX, PIX_MAX, PIX_MAX, PIX_MAX, PIX_MAX, PIX_MAX};
        drive_frame(PIX_MAX, p, 0, 1'b0, 1'b0, 8'd0, 1'b0, -1);
        p = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd1, 8'd0, 8'd1, 8'd0};
        drive_frame(8'd0, p, 0, 1'b0, 1'b0, 8'd0, 1'b0, -1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] p [8];
        logic [7:0] t [3];
        for (int f = 0; f < 3; f++) t[f] = 8'($urandom_range(0, 255));
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 8; i++) p[i] = 8'($urandom_range(0, 255));
            p[f + 1] = t[f];
            drive_frame(t[f], p, 0, 1'b0, (f < 2), (f < 2) ? t[f + 1] : 8'd0, (f > 0), -1);
        end
    endtask

    task automatic test_random();
        logic [7:0] p [8];
        logic [7:0] thr;
        for (int f = 0; f < 4; f++) begin
            thr = 8'($urandom_range(0, 255));
            for (int i = 0; i < 8; i++) p[i] = 8'($urandom_range(0, 255));
            p[$urandom_range(0, 7)] = thr;
            drive_frame(thr, p, 2, 1'b1, 1'b0, 8'd0, 1'b0, -1);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_rdy_toggle();
        test_cfg_hold();
        test_mid_frame_reset();
        test_invert_boundaries();
        test_back_to_back();
        test_random();
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL missing_tokens: %0d outstanding expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
